dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipeline MEM stage (CPU port) and a
//  debug/loader port (DBG port). Grants one access per cycle, drives the 1-cycle-latency
//  synchronous RAM, routes read data back to the owner and stalls the pipeline when it loses.
//  Bounded starvation: DBG is forced through after STARVE_LIMIT consecutive CPU wins.
// PARAMETERS
//  DATA_W       32  data width of both ports and the RAM
//  ADDR_W       32  address width of both ports (word address)
//  DEPTH        15  number of RAM words; addresses >= DEPTH are out of range
//  STARVE_LIMIT 4   consecutive conflict cycles lost by DBG before DBG is forced (>=1)
// PORTS
//  clk        in  1       clock, rising edge
//  rst        in  1       asynchronous reset, active-high
//  cpu_req    in  1       MEM stage access request, held until not stalled
//  cpu_we     in  1       1=store, 0=load
//  cpu_addr   in  ADDR_W  word address (ALU result)
//  cpu_wdata  in  DATA_W  store data
//  cpu_stall  out 1       CPU request not granted this cycle; freeze MEM stage
//  cpu_rvalid out 1       load data valid (cycle after grant)
//  cpu_rdata  out DATA_W  load data
//  cpu_err    out 1       with cpu_rvalid: access was out of range
//  dbg_valid  in  1       DBG request valid (valid/ready handshake)
//  dbg_ready  out 1       DBG request accepted this cycle
//  dbg_we     in  1       1=write, 0=read
//  dbg_addr   in  ADDR_W  word address
//  dbg_wdata  in  DATA_W  write data
//  dbg_rvalid out 1       DBG response valid (cycle after accept, reads AND writes)
//  dbg_rdata  out DATA_W  read data (0 for writes)
//  dbg_err    out 1       with dbg_rvalid: access was out of range
//  mem_en     out 1       RAM access enable
//  mem_we     out 1       RAM write enable
//  mem_addr   out ADDR_W  RAM address
//  mem_wdata  out DATA_W  RAM write data
//  mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en && !mem_we
// BEHAVIOUR
//  - Reset: all registered outputs 0; starve_cnt=0; response FSM=RSP_NONE; pending response dropped.
//  - Grant (combinational): CPU wins if cpu_req && !(dbg_valid && starve_cnt==STARVE_LIMIT);
//    else DBG wins if dbg_valid. cpu_stall = cpu_req && !cpu_grant. dbg_ready = dbg_grant.
//  - mem_* driven combinationally from the winner; mem_en=0 when no grant or addr>=DEPTH.
//  - Out of range: no RAM access; write dropped; response still given next cycle,
//    rdata=0, err=1.
//  - starve_cnt: +1 (saturating at STARVE_LIMIT) on cycles with cpu_grant && dbg_valid;
//    cleared on dbg_grant; held otherwise (dbg_valid low with no grant keeps count).
//  - Response FSM, updated each edge from this cycle's grant: RSP_NONE / RSP_CPU / RSP_DBG
//    (+ registered we, err flags). In RSP_CPU: cpu_rvalid=1 only if the access was a load
//    (stores give no CPU response); cpu_rdata=err?0:mem_rdata. In RSP_DBG: dbg_rvalid=1
//    for reads and writes; dbg_rdata=(we|err)?0:mem_rdata. Otherwise rdata outputs are 0.
//  - Back-to-back grants allowed every cycle; response of cycle N overlaps grant of N+1.
//  - Latency: granted load -> rvalid exactly 1 cycle later; store -> RAM updated at grant edge.
//  - Reset mid-operation: a grant in the reset cycle is void; no rvalid follows reset release.
// TESTING
//  1 CPU load addr 3 (RAM[3]=0xA5A5_0003), no DBG -> cpu_stall=0, mem_en=1; next cycle
//    cpu_rvalid=1, cpu_rdata=0xA5A5_0003, cpu_err=0.
//  2 DBG write addr 7 data 0x1234 alone -> dbg_ready=1, mem_we=1; next cycle dbg_rvalid=1,
//    dbg_rdata=0; CPU load addr 7 afterwards returns 0x1234.
//  3 cpu_req and dbg_valid held continuously, STARVE_LIMIT=4 -> CPU wins 4 cycles, 5th cycle
//    dbg_ready=1 and cpu_stall=1, starve_cnt back to 0, pattern repeats (4 CPU : 1 DBG).
//  4 CPU store addr 20 (DEPTH=15) -> mem_en=0, no RAM change, no cpu_rvalid; CPU load addr 20
//    -> next cycle cpu_rvalid=1, cpu_err=1, cpu_rdata=0.
//  5 DBG read accepted, rst pulsed asynchronously before next edge -> dbg_rvalid stays 0,
//    all outputs 0, starve_cnt=0.
//  6 Alternating CPU load / DBG read every cycle -> each response on correct port, 1 cycle later.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - CPU, debug and RAM signal bundle for the data-memory arbiter
interface dmem_port_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_err;

   logic              dbg_valid;
   logic              dbg_ready;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;
   logic              dbg_err;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
      input  dbg_valid, dbg_we, dbg_addr, dbg_wdata,
      output dbg_ready, dbg_rvalid, dbg_rdata, dbg_err,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
      output dbg_valid, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_ready, dbg_rvalid, dbg_rdata, dbg_err,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - single-port data memory arbiter between CPU MEM stage and debug port
// CPU has priority; DBG is forced through after STARVE_LIMIT consecutive lost conflicts.
module dmem_port_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 32,
   parameter int DEPTH        = 15,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   dmem_port_arbiter_if.slave bus
);
   localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);

   typedef enum logic [1:0] {
      RSP_NONE,
      RSP_CPU,
      RSP_DBG
   } rsp_e;

   rsp_e             rsp_q, rsp_d;
   logic             rsp_we_q, rsp_we_d;
   logic             rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0] starve_q, starve_d;

   logic              cpu_grant;
   logic              dbg_grant;
   logic              any_grant;
   logic              sel_we;
   logic              sel_in_range;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_q     <= RSP_NONE;
         rsp_we_q  <= 1'b0;
         rsp_err_q <= 1'b0;
         starve_q  <= '0;
      end else begin
         rsp_q     <= rsp_d;
         rsp_we_q  <= rsp_we_d;
         rsp_err_q <= rsp_err_d;
         starve_q  <= starve_d;
      end
   end

   always_comb begin
      rsp_d          = RSP_NONE;
      rsp_we_d       = 1'b0;
      rsp_err_d      = 1'b0;
      starve_d       = starve_q;
      bus.cpu_rvalid = 1'b0;
      bus.cpu_rdata  = '0;
      bus.cpu_err    = 1'b0;
      bus.dbg_rvalid = 1'b0;
      bus.dbg_rdata  = '0;
      bus.dbg_err    = 1'b0;

      // Grants are voided while reset is asserted so nothing reaches the RAM
      cpu_grant = !rst && bus.cpu_req && !(bus.dbg_valid && starve_q == STARVE_MAX);
      dbg_grant = !rst && !cpu_grant && bus.dbg_valid;
      any_grant = cpu_grant || dbg_grant;

      sel_we       = cpu_grant ? bus.cpu_we    : bus.dbg_we;
      sel_addr     = cpu_grant ? bus.cpu_addr  : bus.dbg_addr;
      sel_wdata    = cpu_grant ? bus.cpu_wdata : bus.dbg_wdata;
      sel_in_range = sel_addr < DEPTH_A;

      bus.cpu_stall = !rst && bus.cpu_req && !cpu_grant;
      bus.dbg_ready = dbg_grant;
      bus.mem_en    = any_grant && sel_in_range;
      bus.mem_we    = any_grant && sel_in_range && sel_we;
      bus.mem_addr  = any_grant ? sel_addr  : '0;
      bus.mem_wdata = any_grant ? sel_wdata : '0;

      if (dbg_grant) begin
         starve_d = '0;
      end else if (cpu_grant && bus.dbg_valid && starve_q != STARVE_MAX) begin
         starve_d = starve_q + 1'b1;
      end

      if (cpu_grant) begin
         rsp_d = RSP_CPU;
      end else if (dbg_grant) begin
         rsp_d = RSP_DBG;
      end
      rsp_we_d  = any_grant && sel_we;
      rsp_err_d = any_grant && !sel_in_range;

      // Stores on the CPU side produce no response; DBG gets one for both
      case (rsp_q)
         RSP_CPU: begin
            bus.cpu_rvalid = !rsp_we_q;
            bus.cpu_rdata  = rsp_err_q ? '0 : bus.mem_rdata;
            bus.cpu_err    = !rsp_we_q && rsp_err_q;
         end
         RSP_DBG: begin
            bus.dbg_rvalid = 1'b1;
            bus.dbg_rdata  = (rsp_we_q || rsp_err_q) ? '0 : bus.mem_rdata;
            bus.dbg_err    = rsp_err_q;
         end
         default: begin
            bus.cpu_rvalid = 1'b0;
         end
      endcase
   end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard testbench for dmem_port_arbiter
module tb_dmem_port_arbiter;
   localparam int DATA_W       = 32;
   localparam int ADDR_W       = 32;
   localparam int DEPTH        = 15;
   localparam int STARVE_LIMIT = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

   dmem_port_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   typedef struct {
      int          due;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          model_starve = 0;
   logic [31:0] ram [DEPTH];
   logic [31:0] shadow [DEPTH];
   logic [31:0] ram_rd;
   rsp_t        cpu_q[$];
   rsp_t        dbg_q[$];
   rsp_t        mon_e;

   assign bus_if.mem_rdata = ram_rd;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus_if.mem_en && bus_if.mem_addr < DEPTH) begin
         if (bus_if.mem_we) ram[bus_if.mem_addr[3:0]] <= bus_if.mem_wdata;
         else ram_rd <= ram[bus_if.mem_addr[3:0]];
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (bus_if.mem_en) begin
            checks++;
            if (bus_if.mem_addr >= DEPTH) begin
               failures++;
               $display("FAIL mem_en_range addr=%0d exp below %0d", bus_if.mem_addr, DEPTH);
            end
         end
         checks++;
         if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
            mon_e = cpu_q.pop_front();
            if (bus_if.cpu_rvalid !== 1'b1 || bus_if.cpu_rdata !== mon_e.rdata || bus_if.cpu_err !== mon_e.err) begin
               failures++;
               $display("FAIL cpu_rsp got v=%b d=%h e=%b exp v=1 d=%h e=%b", bus_if.cpu_rvalid,
                        bus_if.cpu_rdata, bus_if.cpu_err, mon_e.rdata, mon_e.err);
            end
         end else if (bus_if.cpu_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL cpu_rvalid_unexpected got=%b exp=0", bus_if.cpu_rvalid);
         end
         checks++;
         if (dbg_q.size() > 0 && dbg_q[0].due == cyc) begin
            mon_e = dbg_q.pop_front();
            if (bus_if.dbg_rvalid !== 1'b1 || bus_if.dbg_rdata !== mon_e.rdata || bus_if.dbg_err !== mon_e.err) begin
               failures++;
               $display("FAIL dbg_rsp got v=%b d=%h e=%b exp v=1 d=%h e=%b", bus_if.dbg_rvalid,
                        bus_if.dbg_rdata, bus_if.dbg_err, mon_e.rdata, mon_e.err);
            end
         end else if (bus_if.dbg_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL dbg_rvalid_unexpected got=%b exp=0", bus_if.dbg_rvalid);
         end
      end
   end

   // Drives one cycle of stimulus, advances the reference model and queues expected responses
   task automatic drive_cycle(input logic creq, input logic cwe, input logic [31:0] caddr,
                              input logic [31:0] cwdata, input logic dval, input logic dwe,
                              input logic [31:0] daddr, input logic [31:0] dwdata,
                              output logic exp_stall, output logic exp_ready, output logic exp_en);
      logic        cg, dg, we, inr;
      logic [31:0] a, wd;
      rsp_t        r;
      @(posedge clk);
      #1;
      bus_if.cpu_req   = creq;
      bus_if.cpu_we    = cwe;
      bus_if.cpu_addr  = caddr;
      bus_if.cpu_wdata = cwdata;
      bus_if.dbg_valid = dval;
      bus_if.dbg_we    = dwe;
      bus_if.dbg_addr  = daddr;
      bus_if.dbg_wdata = dwdata;
      cg  = creq && !(dval && model_starve == STARVE_LIMIT);
      dg  = !cg && dval;
      we  = cg ? cwe : dwe;
      a   = cg ? caddr : daddr;
      wd  = cg ? cwdata : dwdata;
      inr = a < DEPTH;
      exp_stall = creq && !cg;
      exp_ready = dg;
      exp_en    = (cg || dg) && inr;
      r.due   = cyc + 1;
      r.err   = !inr;
      r.rdata = (!we && inr) ? shadow[a[3:0]] : 32'h0;
      if (cg || dg) begin
         if (we && inr) shadow[a[3:0]] = wd;
         if (dg) dbg_q.push_back(r);
         else if (!we) cpu_q.push_back(r);
      end
      if (dg) model_starve = 0;
      else if (cg && dval && model_starve < STARVE_LIMIT) model_starve++;
      #3;
   endtask

   task automatic idle(input int n);
      logic s, r, e;
      for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, s, r, e);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus_if.cpu_req = 0; bus_if.cpu_we = 0; bus_if.cpu_addr = 0; bus_if.cpu_wdata = 0;
      bus_if.dbg_valid = 0; bus_if.dbg_we = 0; bus_if.dbg_addr = 0; bus_if.dbg_wdata = 0;
      for (int i = 0; i < DEPTH; i++) begin
         ram[i] = 32'hA5A5_0000 | 32'(i);
         shadow[i] = 32'hA5A5_0000 | 32'(i);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus_if.cpu_stall, bus_if.cpu_rvalid, bus_if.cpu_err, bus_if.dbg_ready, bus_if.dbg_rvalid,
           bus_if.dbg_err, bus_if.mem_en, bus_if.mem_we} !== 8'h0 || bus_if.cpu_rdata !== 32'h0
          || bus_if.dbg_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs stall=%b crv=%b drdy=%b drv=%b en=%b exp all 0", bus_if.cpu_stall,
                  bus_if.cpu_rvalid, bus_if.dbg_ready, bus_if.dbg_rvalid, bus_if.mem_en);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      model_starve = 0;
   endtask

   task automatic test_cpu_load;
      logic s, r, e;
      drive_cycle(1, 0, 3, 0, 0, 0, 0, 0, s, r, e);
      checks++;
      if (bus_if.cpu_stall !== s || bus_if.mem_en !== e || bus_if.mem_we !== 1'b0 || bus_if.mem_addr !== 32'd3) begin
         failures++;
         $display("FAIL cpu_load_issue stall=%b en=%b we=%b addr=%0d exp stall=%b en=%b we=0 addr=3",
                  bus_if.cpu_stall, bus_if.mem_en, bus_if.mem_we, bus_if.mem_addr, s, e);
      end
      idle(1);
   endtask

   task automatic test_dbg_write;
      logic s, r, e;
      drive_cycle(0, 0, 0, 0, 1, 1, 7, 32'h1234, s, r, e);
      checks++;
      if (bus_if.dbg_ready !== r || bus_if.mem_we !== 1'b1 || bus_if.mem_wdata !== 32'h1234) begin
         failures++;
         $display("FAIL dbg_write_issue ready=%b we=%b wdata=%h exp ready=%b we=1 wdata=1234",
                  bus_if.dbg_ready, bus_if.mem_we, bus_if.mem_wdata, r);
      end
      drive_cycle(1, 0, 7, 0, 0, 0, 0, 0, s, r, e);
      idle(1);
   endtask

   task automatic test_starvation;
      logic s, r, e;
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1, 0, 32'(i % DEPTH), 0, 1, 0, 32'((i + 5) % DEPTH), 0, s, r, e);
         checks++;
         if (bus_if.dbg_ready !== r || bus_if.cpu_stall !== s || bus_if.dbg_ready !== (i % 5 == 4)) begin
            failures++;
            $display("FAIL starve_cycle%0d ready=%b stall=%b exp ready=%b stall=%b", i,
                     bus_if.dbg_ready, bus_if.cpu_stall, r, s);
         end
      end
      idle(1);
   endtask

   task automatic test_out_of_range;
      logic s, r, e;
      drive_cycle(1, 1, 20, 32'hDEAD_BEEF, 0, 0, 0, 0, s, r, e);
      checks++;
      if (bus_if.mem_en !== 1'b0 || bus_if.cpu_stall !== 1'b0) begin
         failures++;
         $display("FAIL oor_store en=%b stall=%b exp en=0 stall=0", bus_if.mem_en, bus_if.cpu_stall);
      end
      drive_cycle(1, 0, 20, 0, 0, 0, 0, 0, s, r, e);
      checks++;
      if (bus_if.mem_en !== 1'b0) begin
         failures++;
         $display("FAIL oor_load en=%b exp 0", bus_if.mem_en);
      end
      drive_cycle(0, 0, 0, 0, 1, 0, 15, 0, s, r, e);
      drive_cycle(0, 0, 0, 0, 1, 1, 99, 32'h5555, s, r, e);
      drive_cycle(1, 0, 14, 0, 0, 0, 0, 0, s, r, e);
      idle(1);
   endtask

   task automatic test_back_to_back;
      logic s, r, e;
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) drive_cycle(1, 0, 32'(i), 0, 0, 0, 0, 0, s, r, e);
         else if (i == 5) drive_cycle(0, 0, 0, 0, 1, 1, 32'(i), 32'hCAFE_0000, s, r, e);
         else drive_cycle(0, 0, 0, 0, 1, 0, 32'(i + 6), 0, s, r, e);
         checks++;
         if (bus_if.dbg_ready !== r || bus_if.cpu_stall !== s || bus_if.mem_en !== e) begin
            failures++;
            $display("FAIL b2b_cycle%0d ready=%b stall=%b en=%b exp %b %b %b", i, bus_if.dbg_ready,
                     bus_if.cpu_stall, bus_if.mem_en, r, s, e);
         end
      end
      drive_cycle(1, 0, 5, 0, 0, 0, 0, 0, s, r, e);
      idle(1);
   endtask

   task automatic test_reset_mid;
      logic s, r, e;
      drive_cycle(1, 0, 1, 0, 1, 0, 2, 0, s, r, e);
      drive_cycle(1, 0, 1, 0, 1, 0, 2, 0, s, r, e);
      drive_cycle(0, 0, 0, 0, 1, 0, 2, 0, s, r, e);
      checks++;
      if (bus_if.dbg_ready !== 1'b1) begin
         failures++;
         $display("FAIL rmid_accept ready=%b exp 1", bus_if.dbg_ready);
      end
      #2 rst = 1'b1;
      cpu_q.delete();
      dbg_q.delete();
      #1;
      checks++;
      if ({bus_if.dbg_ready, bus_if.dbg_rvalid, bus_if.cpu_rvalid, bus_if.mem_en, bus_if.cpu_stall} !== 5'b0
          || bus_if.dbg_rdata !== 32'h0) begin
         failures++;
         $display("FAIL rmid_outputs ready=%b drv=%b crv=%b en=%b exp all 0", bus_if.dbg_ready,
                  bus_if.dbg_rvalid, bus_if.cpu_rvalid, bus_if.mem_en);
      end
      @(posedge clk);
      #2;
      checks++;
      if (bus_if.dbg_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL rmid_rvalid got=%b exp 0", bus_if.dbg_rvalid);
      end
      bus_if.dbg_valid = 0;
      rst = 1'b0;
      model_starve = 0;
      idle(2);
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1, 0, 4, 0, 1, 0, 9, 0, s, r, e);
         checks++;
         if (bus_if.dbg_ready !== (i == 4)) begin
            failures++;
            $display("FAIL rmid_starve_cleared cycle%0d ready=%b exp %b", i, bus_if.dbg_ready, i == 4);
         end
      end
      idle(1);
   endtask

   initial begin
      test_reset;
      test_cpu_load;
      test_dbg_write;
      test_starvation;
      test_out_of_range;
      test_back_to_back;
      test_reset_mid;
      idle(2);
      checks++;
      if (cpu_q.size() != 0 || dbg_q.size() != 0) begin
         failures++;
         $display("FAIL pending_responses cpu=%0d dbg=%0d exp 0 0", cpu_q.size(), dbg_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
